// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller feeding program_counter. It fetches the word at pc,
// hands normal instructions to decode, and resolves JMP/JZ/HALT locally.
module fetch_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] pc,
  input  logic        zero,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  output logic [15:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        inc,
  output logic        add,
  output logic        sub,
  output logic [15:0] offset,
  output logic        halt
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    ISSUE,
    UPDATE,
    HALTED
  } state_t;

  state_t      state;
  logic [15:0] ir;

  assign imem_addr = pc;

  // Outputs are registered alongside the state so each one is set on the edge
  // that enters the state it belongs to and cleared on the edge that leaves it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      ir          <= 16'h0000;
      imem_req    <= 1'b0;
      instr       <= 16'h0000;
      instr_valid <= 1'b0;
      inc         <= 1'b0;
      add         <= 1'b0;
      sub         <= 1'b0;
      offset      <= 16'h0000;
      halt        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end

        FETCH: begin
          if (imem_ack) begin
            ir       <= imem_data;
            imem_req <= 1'b0;
            state    <= DECODE;
          end
        end

        DECODE: begin
          case (ir[15:12])
            4'hF: begin
              halt  <= 1'b1;
              state <= HALTED;
            end
            4'hE: begin
              add    <= ~ir[11];
              sub    <= ir[11];
              offset <= {5'b00000, ir[10:0]};
              state  <= UPDATE;
            end
            // A not-taken JZ simply steps over itself.
            4'hD: begin
              if (zero) begin
                add    <= ~ir[11];
                sub    <= ir[11];
                offset <= {5'b00000, ir[10:0]};
              end else begin
                inc    <= 1'b1;
                offset <= 16'h0000;
              end
              state <= UPDATE;
            end
            default: begin
              instr       <= ir;
              instr_valid <= 1'b1;
              state       <= ISSUE;
            end
          endcase
        end

        ISSUE: begin
          if (instr_ready) begin
            instr       <= 16'h0000;
            instr_valid <= 1'b0;
            inc         <= 1'b1;
            offset      <= 16'h0000;
            state       <= UPDATE;
          end
        end

        UPDATE: begin
          inc      <= 1'b0;
          add      <= 1'b0;
          sub      <= 1'b0;
          offset   <= 16'h0000;
          imem_req <= 1'b1;
          state    <= FETCH;
        end

        HALTED: begin
          state <= HALTED;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: a behavioural program counter plus an
// instruction-level model of where the next fetch must land and which command issues.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] pc;
  logic        zero = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_data = 16'h0000;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        inc, add, sub;
  logic [15:0] offset;
  logic        halt;

  logic        pcLoadEn = 1'b0;
  logic [15:0] pcLoadVal = 16'h0000;
  logic [15:0] expPc;
  int          testsRun = 0;
  int          testsFailed = 0;

  fetch_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .zero        (zero),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .inc         (inc),
    .add         (add),
    .sub         (sub),
    .offset      (offset),
    .halt        (halt)
  );

  always #5 clk = ~clk;

  // Stand-in for program_counter; the load port lets the bench place pc anywhere.
  always @(posedge clk) begin
    if (pcLoadEn)    pc <= pcLoadVal;
    else if (!reset) pc <= 16'h0000;
    else if (inc)    pc <= pc + 16'd1;
    else if (add)    pc <= pc + offset;
    else if (sub)    pc <= pc - offset;
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, "_ctl"}, {10'b0, imem_req, instr_valid, inc, add, sub, halt}, 16'h0000);
    checkOutput({tag, "_offset"}, offset, 16'h0000);
  endtask

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ack, input logic [15:0] data, input logic z, input logic rdy);
    imem_ack    = ack;
    imem_data   = data;
    zero        = z;
    instr_ready = rdy;
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic loadPc(input logic [15:0] val);
    pcLoadEn  = 1'b1;
    pcLoadVal = val;
    stepClk();
    pcLoadEn  = 1'b0;
    expPc     = val;
  endtask

  // Runs one whole instruction from FETCH back to the next FETCH (or into HALTED).
  task automatic runInstr(input logic [15:0] data, input int waits, input logic z, input int readyDelay);
    logic        taken;
    logic [15:0] disp;
    disp = {5'b00000, data[10:0]};
    checkOutput("fetch_req", {15'b0, imem_req}, 16'h0001);
    checkOutput("fetch_addr", imem_addr, expPc);
    for (int w = 0; w < waits; w++) begin
      applyStimulus(1'b0, 16'($urandom), z, rbit());
      stepClk();
      checkOutput("wait_req", {15'b0, imem_req}, 16'h0001);
      checkOutput("wait_valid", {15'b0, instr_valid}, 16'h0000);
    end
    applyStimulus(1'b1, data, z, rbit());
    stepClk();
    applyStimulus(rbit(), 16'($urandom), z, rbit());
    checkQuiet("decode");
    stepClk();
    if (data[15:12] == 4'hF) begin
      checkOutput("halt", {15'b0, halt}, 16'h0001);
      for (int c = 0; c < 20; c++) begin
        applyStimulus(rbit(), 16'($urandom), rbit(), rbit());
        stepClk();
        checkOutput("halted_quiet", {11'b0, imem_req, inc, add, sub, instr_valid}, 16'h0000);
        checkOutput("halt_hold", {15'b0, halt}, 16'h0001);
      end
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
    end else if (data[15:12] == 4'hE || data[15:12] == 4'hD) begin
      taken = (data[15:12] == 4'hE) || z;
      applyStimulus(rbit(), 16'($urandom), rbit(), rbit());
      checkOutput("upd_inc", {15'b0, inc}, {15'b0, ~taken});
      checkOutput("upd_add", {15'b0, add}, {15'b0, taken & ~data[11]});
      checkOutput("upd_sub", {15'b0, sub}, {15'b0, taken & data[11]});
      checkOutput("upd_offset", offset, taken ? disp : 16'h0000);
      checkOutput("upd_valid", {15'b0, instr_valid}, 16'h0000);
      if (!taken)       expPc = expPc + 16'd1;
      else if (data[11]) expPc = expPc - disp;
      else               expPc = expPc + disp;
      stepClk();
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
      checkOutput("after_upd_cmds", {13'b0, inc, add, sub}, 16'h0000);
    end else begin
      for (int i = 0; i <= readyDelay; i++) begin
        checkOutput("issue_valid", {15'b0, instr_valid}, 16'h0001);
        checkOutput("issue_instr", instr, data);
        checkOutput("issue_cmds", {13'b0, inc, add, sub}, 16'h0000);
        applyStimulus(rbit(), 16'($urandom), rbit(), (i == readyDelay));
        stepClk();
      end
      applyStimulus(1'b0, 16'h0000, 1'b0, rbit());
      checkOutput("upd_inc", {15'b0, inc}, 16'h0001);
      checkOutput("upd_addsub", {14'b0, add, sub}, 16'h0000);
      checkOutput("upd_offset", offset, 16'h0000);
      checkOutput("upd_valid", {15'b0, instr_valid}, 16'h0000);
      expPc = expPc + 16'd1;
      stepClk();
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
      checkOutput("after_upd_cmds", {13'b0, inc, add, sub}, 16'h0000);
    end
  endtask

  initial begin
    logic [15:0] word;
    int          kind;

    // Power-up reset, then the first request on the second cycle.
    reset = 1'b0;
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
    stepClk();
    stepClk();
    checkQuiet("reset_state");
    reset = 1'b1;
    expPc = 16'h0000;
    stepClk();
    runInstr(16'h1234, 2, 1'b0, 0);
    runInstr(16'h5A5A, 1, 1'b0, 3);

    loadPc(16'h0010);
    runInstr(16'hE805, 0, 1'b0, 0);
    checkOutput("jmp_back_target", imem_addr, 16'h000B);
    runInstr(16'hD003, 0, 1'b0, 0);
    loadPc(16'hFFFE);
    runInstr(16'hD003, 1, 1'b1, 0);
    checkOutput("jz_wrap_target", imem_addr, 16'h0001);

    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 3);
      word = 16'($urandom);
      if (kind == 2)      word[15:12] = 4'hE;
      else if (kind == 3) word[15:12] = 4'hD;
      else                word[15:12] = 4'($urandom_range(0, 12));
      runInstr(word, $urandom_range(0, 3), rbit(), $urandom_range(0, 3));
    end

    // Reset held for two cycles while an instruction is being offered to decode.
    applyStimulus(1'b1, 16'h2222, 1'b0, 1'b0);
    stepClk();
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
    stepClk();
    checkOutput("pre_reset_valid", {15'b0, instr_valid}, 16'h0001);
    reset = 1'b0;
    stepClk();
    checkQuiet("rst_issue1");
    checkOutput("rst_issue_instr", instr, 16'h0000);
    stepClk();
    checkQuiet("rst_issue2");
    reset = 1'b1;
    expPc = 16'h0000;
    stepClk();
    runInstr(16'h0777, 0, 1'b0, 1);

    // Reset mid-fetch; an ack arriving during IDLE must not be captured.
    reset = 1'b0;
    stepClk();
    checkQuiet("rst_fetch");
    reset = 1'b1;
    expPc = 16'h0000;
    applyStimulus(1'b1, 16'hE123, 1'b1, 1'b1);
    stepClk();
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
    checkOutput("late_ack_ignored", {14'b0, imem_req, instr_valid}, 16'h0002);
    runInstr(16'h0ABC, 0, 1'b0, 0);

    runInstr(16'hF000, 1, 1'b0, 0);
    reset = 1'b0;
    stepClk();
    checkOutput("halt_cleared", {15'b0, halt}, 16'h0000);
    checkQuiet("post_halt_reset");
    reset = 1'b1;
    expPc = 16'h0000;
    stepClk();
    runInstr(16'h0042, 0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
